// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit with MTHI/MTLO; `define MULDIV_DIVZERO_FLAG_EN adds the divz output
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_FLAG_EN
  ,
  output logic             divz
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_m;
  logic               r_div;
  logic               r_neg;
  logic               r_sa;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               w_idle;
  logic               w_accept;
  logic               w_dz;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_r;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  assign w_idle   = r_state == S_IDLE;
  assign w_accept = start && w_idle && !op[2];
  assign w_dz     = op[1] && B == '0;
  // a zero divisor runs unsigned so the quotient saturates to all ones and the remainder is A's raw bits
  assign w_sa     = !op[0] && A[WIDTH-1] && !w_dz;
  assign w_sb     = !op[0] && B[WIDTH-1];
  assign w_ma     = w_sa ? -A : A;
  assign w_mb     = w_sb ? -B : B;
  assign w_add    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_p[0] ? r_m : {WIDTH{1'b0}}};
  assign w_r      = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_ge     = w_r >= {1'b0, r_m};
  assign w_diff   = w_r[WIDTH-1:0] - r_m;
  assign w_step   = r_div ? (w_ge ? {w_diff, r_p[WIDTH-2:0], 1'b1} : {w_r[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0})
                          : {w_add, r_p[WIDTH-1:1]};
  assign w_prod   = r_neg ? -r_p : r_p;
  assign w_quo    = r_neg ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem    = r_sa ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
  assign busy     = !w_idle;
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  // sequencer and shared shift register: {acc, multiplier} for multiply, {remainder, dividend} for divide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_div   <= 1'b0;
      r_neg   <= 1'b0;
      r_sa    <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_div   <= op[1];
      r_neg   <= w_sa ^ w_sb;
      r_sa    <= w_sa;
      r_m     <= op[1] ? w_mb : w_ma;
      r_p     <= {{WIDTH{1'b0}}, op[1] ? w_ma : w_mb};
    end else if (r_state == S_RUN) begin
      r_p     <= w_step;
      r_cnt   <= r_cnt + CNT_W'(1);
      r_state <= &r_cnt ? S_FIX : S_RUN;
    end else if (r_state == S_FIX) begin
      r_state <= S_IDLE;
    end
  end
  // architectural HI/LO: sign-corrected result on completion, direct writes from MTHI/MTLO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= r_state == S_FIX;
      if (r_state == S_FIX) begin
        r_hi <= r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        r_lo <= r_div ? w_quo : w_prod[WIDTH-1:0];
      end else if (start && w_idle && op == 3'b100) begin
        r_hi <= A;
      end else if (start && w_idle && op == 3'b101) begin
        r_lo <= A;
      end
    end
  end
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic r_dz;
  logic r_divz;
  assign divz = r_divz;
  // divide-by-zero is captured at acceptance and published with the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dz   <= 1'b0;
      r_divz <= 1'b0;
    end else begin
      r_dz   <= w_accept ? w_dz : r_dz;
      r_divz <= r_state == S_FIX ? r_dz : r_divz;
    end
  end
`endif
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic        divz;
`endif
  always #5 clk = ~clk;
  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MULDIV_DIVZERO_FLAG_EN
    , .divz(divz)
`endif
  );
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int     sa = a;
    int     sb = b;
    longint p;
    if (o == 3'd0) begin
      p = longint'(sa) * longint'(sb);
      return p;
    end
    if (o == 3'd1) return {32'd0, a} * {32'd0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (o == 3'd2) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o;
    A = a;
    B = b;
    start = 1'b1;
    {m_hi, m_lo} = model(o, a, b);
    m_dz = o[1] && b == 0;
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask
  task automatic wait_done(input int pulse_at);
    int k = 0;
    int nb = 0;
    while (!done && k < 40) begin
      if (busy) nb++;
      if (k == pulse_at) begin
        op = 3'd3;
        A = 32'd9;
        B = 32'd3;
        start = 1'b1;
      end
      if (k == pulse_at + 1) start = 1'b0;
      @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'd33);
    check("busy_cycles", 64'(nb), 64'd33);
    check("busy_at_done", 64'(busy), 64'd0);
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
`ifdef MULDIV_DIVZERO_FLAG_EN
    check("divz", 64'(divz), 64'(m_dz));
`endif
  endtask
  initial begin
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(-5);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(-5);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(-5);
    issue(3'd3, 32'd100, 32'd0);
    wait_done(-5);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(-5);
    issue(3'd1, 32'd5, 32'd6);
    wait_done(10);
    issue(3'd3, 32'd9, 32'd3);
    wait_done(-5);
    op = 3'd4;
    A = 32'h1234_5678;
    start = 1'b1;
    @(negedge clk);
    m_hi = 32'h1234_5678;
    check("mthi_hi", 64'(hi), 64'(m_hi));
    check("mthi_busy", 64'(busy), 64'd0);
    op = 3'd5;
    A = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    m_lo = 32'h9ABC_DEF0;
    check("mtlo_lo", 64'(lo), 64'(m_lo));
    check("mtlo_hi", 64'(hi), 64'(m_hi));
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);
    op = 3'd6;
    A = 32'hDEAD_BEEF;
    start = 1'b1;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    check("rsvd_hi", 64'(hi), 64'(m_hi));
    check("rsvd_lo", 64'(lo), 64'(m_lo));
    check("rsvd_busy", 64'(busy), 64'd0);
    issue(3'd0, 32'd1000, 32'd1000);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(3'd0, 32'd2, 32'd3);
    wait_done(-5);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(o, a, b);
      wait_done(-5);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
